// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, FSM encoding and PC arithmetic helpers for the IF-stage fetch sequencer.
package fetch_sequencer_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [PC_W-1:0] DEF_IRQ_VEC   = 32'h8000_0008;
    localparam logic [PC_W-1:0] DEF_EXC_VEC   = 32'h8000_0010;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DEFER
    } fsm_t;

    // Sequential successor: the mode bit never takes the carry out of bit 30.
    function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
        seq_pc = (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFC);
    endfunction

    // Redirect target: word aligned, and user code can never reach kernel space.
    function automatic logic [PC_W-1:0] clamp_tgt(input logic [PC_W-1:0] tgt, input logic kernel);
        clamp_tgt = tgt & {kernel, {(PC_W-3){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_irq_sync.sv
// Synchronises the asynchronous timer interrupt level and flags its rising edge.
// Rise is visible SYNC_STAGES edges after irq_i goes high; one-cycle pulse.
module fetch_sequencer_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_irq,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage PC owner: next-PC priority mux over exception, interrupt, stall, branch, jump, sequential.
// One-cycle latency to pc_o; flush outputs are combinational from the current-cycle redirect.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC   = DEF_RESET_VEC,
    parameter logic [PC_W-1:0] IRQ_VEC     = DEF_IRQ_VEC,
    parameter logic [PC_W-1:0] EXC_VEC     = DEF_EXC_VEC,
    parameter int              SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_tgt_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_tgt_i,
    input  logic            exc_i,
    input  logic [PC_W-1:0] id_pc_i,
    input  logic            irq_i,
    output logic [PC_W-1:0] pc_o,
    output logic            if_flush_o,
    output logic            id_flush_o,
    output logic [PC_W-1:0] epc_o,
    output logic            kernel_o
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_epc;
    logic            r_irq_pend;
    fsm_t            r_state;

    logic w_irq_rise;
    logic w_pend;
    logic w_kernel;
    logic w_active;
    logic w_hazard;
    logic w_take;

    fetch_sequencer_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk    (clk),
        .reset  (reset),
        .i_irq  (irq_i),
        .o_rise (w_irq_rise)
    );

    // A freshly detected edge is takeable in the same cycle it appears.
    assign w_pend   = r_irq_pend | w_irq_rise;
    assign w_kernel = r_pc[PC_W-1];
    assign w_active = (r_state != ST_BOOT);
    assign w_hazard = stall_i | branch_taken_i | jump_i;
    assign w_take   = w_active & w_pend & ~w_kernel & ~w_hazard & ~exc_i;

    assign if_flush_o = w_active & (exc_i | w_take | (~stall_i & (branch_taken_i | jump_i)));
    assign id_flush_o = w_active & exc_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_irq_pend <= 1'b0;
            r_state    <= ST_BOOT;
        end else begin
            if (w_take) begin
                r_irq_pend <= 1'b0;
            end else if (w_irq_rise) begin
                r_irq_pend <= 1'b1;
            end

            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    if (w_take) begin
                        r_state <= ST_RUN;
                    end else if (w_pend && !w_kernel && w_hazard) begin
                        r_state <= ST_DEFER;
                    end

                    // Exception outranks everything, including stall and a pending take.
                    if (exc_i) begin
                        r_epc <= id_pc_i;
                        r_pc  <= EXC_VEC;
                    end else if (w_take) begin
                        r_epc <= r_pc;
                        r_pc  <= IRQ_VEC;
                    end else if (!stall_i) begin
                        if (branch_taken_i) begin
                            r_pc <= clamp_tgt(branch_tgt_i, w_kernel);
                        end else if (jump_i) begin
                            r_pc <= clamp_tgt(jump_tgt_i, w_kernel);
                        end else begin
                            r_pc <= seq_pc(r_pc);
                        end
                    end
                end
            endcase
        end
    end

    assign pc_o     = r_pc;
    assign epc_o    = r_epc;
    assign kernel_o = r_pc[PC_W-1];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised and directed scoreboard bench for fetch_sequencer against a behavioural fetch model.
module tb_fetch_sequencer;

    localparam int S = 2;
    localparam logic [31:0] RST_V = 32'h8000_0000;
    localparam logic [31:0] IRQ_V = 32'h8000_0008;
    localparam logic [31:0] EXC_V = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0, branch_taken_i = 1'b0, jump_i = 1'b0, exc_i = 1'b0, irq_i = 1'b0;
    logic [31:0] branch_tgt_i = '0, jump_tgt_i = '0, id_pc_i = '0;
    logic [31:0] pc_o, epc_o;
    logic        if_flush_o, id_flush_o, kernel_o;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_tgt_i   (branch_tgt_i),
        .jump_i         (jump_i),
        .jump_tgt_i     (jump_tgt_i),
        .exc_i          (exc_i),
        .id_pc_i        (id_pc_i),
        .irq_i          (irq_i),
        .pc_o           (pc_o),
        .if_flush_o     (if_flush_o),
        .id_flush_o     (id_flush_o),
        .epc_o          (epc_o),
        .kernel_o       (kernel_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fi;
        logic        fd;
        logic [31:0] pc;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    bit   hist[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference state: architectural view only (PC, EPC, outstanding interrupt, boot slot).
    logic [31:0] m_pc, m_epc;
    bit          m_pend, m_boot;
    bit          irq = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hv(input int i);
        return (i < 0) ? 1'b0 : hist[i];
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] pc);
        longint low;
        low = (longint'(pc % 32'h8000_0000) + 4) % 64'h8000_0000;
        return (pc[31] ? 32'h8000_0000 : 32'h0) + 32'(low);
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] t, input bit k);
        logic [31:0] a;
        a = (t / 4) * 4;
        if (!k && a >= 32'h8000_0000) a = a - 32'h8000_0000;
        return a;
    endfunction

    task automatic model_reset();
        m_pc = RST_V; m_epc = 32'h0; m_pend = 1'b0; m_boot = 1'b1;
        hist.delete();
    endtask

    // Drive one cycle (called at a falling edge), predict its outcome, queue it, advance.
    task automatic cyc(input bit st, input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt, input bit ex, input logic [31:0] ip);
        exp_t e;
        bit   rise, pend, take, k;
        int   c;
        stall_i = st; branch_taken_i = br; branch_tgt_i = bt;
        jump_i = jp; jump_tgt_i = jt; exc_i = ex; id_pc_i = ip; irq_i = irq;
        hist.push_back(irq);
        c = hist.size() - 1;
        // Interrupt becomes visible S cycles after the level change, once per low-to-high transition.
        rise = hv(c - S) && !hv(c - S - 1);
        pend = m_pend || rise;
        k = m_pc[31];
        if (m_boot) begin
            e.fi = 1'b0; e.fd = 1'b0;
            m_boot = 1'b0;
            m_pend = pend;
        end else begin
            take = pend && !k && !st && !br && !jp && !ex;
            e.fi = ex || take || (!st && (br || jp));
            e.fd = ex;
            if (ex) begin
                m_epc = ip; m_pc = EXC_V;
            end else if (take) begin
                m_epc = m_pc; m_pc = IRQ_V;
            end else if (!st) begin
                if (br)      m_pc = tgt(bt, k);
                else if (jp) m_pc = tgt(jt, k);
                else         m_pc = nxt(m_pc);
            end
            m_pend = take ? 1'b0 : pend;
        end
        e.pc = m_pc; e.epc = m_epc;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jmp(input logic [31:0] t);
        cyc(0, 0, 0, 1, t, 0, 0);
    endtask

    // Monitor: flush is combinational (checked mid-cycle), PC/EPC after the edge.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                chk("if_flush", 32'(if_flush_o), 32'(it.fi));
                chk("id_flush", 32'(id_flush_o), 32'(it.fd));
                @(posedge clk);
                #1;
                chk("pc", pc_o, it.pc);
                chk("epc", epc_o, it.epc);
                chk("kernel", 32'(kernel_o), 32'(it.pc[31]));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc_o, RST_V);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_if_flush", 32'(if_flush_o), 32'h0);
        chk("rst_id_flush", 32'(id_flush_o), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        idle(3);                                  // boot hold then sequential
        jmp(32'h0000_0010);                       // kernel return to user
        jmp(32'h0000_0028);
        jmp(32'h8000_0040);                       // user cannot enter kernel
        jmp(32'h0000_0033);                       // low bits truncated
        cyc(0, 1, 32'h0000_0060, 1, 32'h0000_0070, 0, 0);
        jmp(32'h0000_0020);

        irq = 1'b1;                               // interrupt, then held high in kernel
        idle(3);
        idle(4);
        jmp(m_epc);
        idle(3);
        irq = 1'b0;
        idle(3);

        irq = 1'b1;                               // deferred behind stalls and a branch
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h0000_0300, 0, 0, 0, 0);
        cyc(0, 1, 32'h0000_0200, 0, 0, 0, 0);
        idle(2);
        jmp(m_epc);
        irq = 1'b0;
        idle(3);

        irq = 1'b1;                               // exception collides with take
        idle(2);
        cyc(1, 0, 0, 0, 0, 1, 32'h0000_0030);
        idle(2);
        jmp(32'h0000_0100);
        idle(2);
        irq = 1'b0;
        jmp(m_epc);

        jmp(32'h7FFF_FFFC);                       // wrap below kernel space
        idle(2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99, 0) < 6) irq = ~irq;
            cyc($urandom_range(99, 0) < 15, $urandom_range(99, 0) < 10, $urandom,
                $urandom_range(99, 0) < 12, ($urandom_range(1, 0) == 1) ? $urandom : ($urandom & 32'h0000_0FFF),
                $urandom_range(99, 0) < 3, $urandom);
        end

        stall_i = 0; branch_taken_i = 0; jump_i = 0; exc_i = 0; irq = 1'b0; irq_i = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;                             // asynchronous mid-run reset
        #1;
        chk("midrst_pc", pc_o, RST_V);
        chk("midrst_epc", epc_o, 32'h0);
        chk("midrst_if_flush", 32'(if_flush_o), 32'h0);
        chk("midrst_kernel", 32'(kernel_o), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle(3);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
